// File: rtl/oflow_mem_buffer_wrapper_pkg.sv
// Shared widths, types and helpers for the history-frame buffer.
// Slot/line arithmetic lives here so the wrapper stays focused on sequencing.
package oflow_mem_buffer_wrapper_pkg;

  localparam int DATA_WIDTH                  = 32;
  localparam int TOTAL_FRAME_NUM_WIDTH       = 8;
  localparam int NUM_OF_HISTORY_FRAMES_WIDTH = 3;
  localparam int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6;
  localparam int HISTORY_DEPTH               = 5;
  localparam int LINES_PER_FRAME             = 16;
  localparam int SLOT_WIDTH                  = $clog2(HISTORY_DEPTH);
  localparam int LINE_WIDTH                  = $clog2(LINES_PER_FRAME);
  localparam int LINE_CNT_WIDTH              = LINE_WIDTH + 1;
  localparam int RAM_DEPTH                   = HISTORY_DEPTH * LINES_PER_FRAME;
  localparam int ADDR_WIDTH                  = $clog2(RAM_DEPTH);

  typedef logic [SLOT_WIDTH-1:0]                  slot_t;
  typedef logic [LINE_WIDTH-1:0]                  line_t;
  typedef logic [LINE_CNT_WIDTH-1:0]              lcnt_t;
  typedef logic [ADDR_WIDTH-1:0]                  addr_t;
  typedef logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] hist_t;
  typedef logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_t;
  typedef logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  bbox_t;
  typedef lcnt_t                                  lcnt_arr_t [HISTORY_DEPTH];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_FETCH,
    ST_READ_WAIT
  } state_t;

  // Slot holding the frame k steps back from base, wrapping around the ring.
  function automatic slot_t slot_back(input slot_t base, input int k);
    int s;
    s = (int'(base) - k) % HISTORY_DEPTH;
    if (s < 0) s = s + HISTORY_DEPTH;
    return slot_t'(s);
  endfunction

  function automatic addr_t line_addr(input slot_t slot, input line_t line);
    return addr_t'(int'(slot) * LINES_PER_FRAME + int'(line));
  endfunction

  // Two bbox per line, capped to the physical lines of a slot.
  function automatic lcnt_t calc_target(input bbox_t bbox);
    int t;
    t = (int'(bbox) + 1) / 2;
    if (t > LINES_PER_FRAME) t = LINES_PER_FRAME;
    return lcnt_t'(t);
  endfunction

  function automatic hist_t calc_depth(input hist_t nh, input frame_t fn);
    int h;
    h = int'(nh);
    if (int'(fn) < h) h = int'(fn);
    if (h > HISTORY_DEPTH) h = HISTORY_DEPTH;
    return hist_t'(h);
  endfunction

  // Smallest history index >= from (and < h) whose slot holds data; h when none.
  function automatic hist_t next_valid(input int from, input hist_t h,
                                       input slot_t base, input lcnt_arr_t cnts);
    hist_t res;
    res = h;
    for (int kk = HISTORY_DEPTH - 1; kk >= 0; kk--) begin
      if (kk >= from && kk < int'(h) && cnts[slot_back(base, kk)] != '0)
        res = hist_t'(kk);
    end
    return res;
  endfunction

endpackage

// File: rtl/oflow_mem_buffer_ram.sv
// Single-port synchronous RAM holding every line of every history slot.
// The read register only updates on a read, so the last line stays on the bus.
module oflow_mem_buffer_ram
  import oflow_mem_buffer_wrapper_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_N,
  input  logic                    en,
  input  logic                    we,
  input  addr_t                   addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [2*DATA_WIDTH-1:0] rdata
);

  logic [2*DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [2*DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)        rdata_reg <= '0;
    else if (en && !we)  rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/oflow_mem_buffer_wrapper.sv
// History-frame buffer: records frames line by line into a ring of slots and
// replays the most recent ones, newest first, to the similarity PEs.
module oflow_mem_buffer_wrapper
  import oflow_mem_buffer_wrapper_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   rnw_st,
  input  logic                                   start_write,
  input  logic                                   start_read,
  input  logic                                   ready_from_core,
  input  logic                                   read_new_line,
  input  logic [DATA_WIDTH-1:0]                  data_in_0,
  input  logic [DATA_WIDTH-1:0]                  data_in_1,
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
  output logic                                   done_write,
  output logic                                   done_read,
  output logic [DATA_WIDTH-1:0]                  data_out_0,
  output logic [DATA_WIDTH-1:0]                  data_out_1,
  output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] counter_of_history_frame_to_interface
);

  state_t    state_reg, state_next;
  slot_t     wr_slot_reg, wr_slot_next;
  lcnt_t     target_reg, target_next;
  hist_t     h_reg, h_next;
  hist_t     k_reg, k_next;
  line_t     line_reg, line_next;
  hist_t     counter_reg, counter_next;
  logic      done_write_reg, done_write_next;
  logic      done_read_reg, done_read_next;
  lcnt_arr_t line_cnt_reg;

  logic                    cnt_clear, cnt_inc;
  logic                    ram_en, ram_we;
  addr_t                   ram_addr;
  logic [2*DATA_WIDTH-1:0] ram_rdata;

  logic  wr_go, rd_go;
  slot_t new_slot, rd_slot;
  lcnt_t new_target, rd_cnt, wr_cnt;
  hist_t new_h, first_k, nxt_k;

  assign wr_go      = start_write & ~rnw_st;
  assign rd_go      = start_read & rnw_st;
  assign new_slot   = (frame_num == '0) ? '0 :
                      (wr_slot_reg == slot_t'(HISTORY_DEPTH - 1)) ? '0 : wr_slot_reg + 1'b1;
  assign new_target = calc_target(num_of_bbox_in_frame);
  assign new_h      = calc_depth(num_of_history_frames, frame_num);
  assign first_k    = next_valid(0, new_h, wr_slot_reg, line_cnt_reg);
  assign nxt_k      = next_valid(int'(k_reg) + 1, h_reg, wr_slot_reg, line_cnt_reg);
  assign rd_slot    = slot_back(wr_slot_reg, int'(k_reg));
  assign rd_cnt     = line_cnt_reg[rd_slot];
  assign wr_cnt     = line_cnt_reg[wr_slot_reg];

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    wr_slot_next    = wr_slot_reg;
    target_next     = target_reg;
    h_next          = h_reg;
    k_next          = k_reg;
    line_next       = line_reg;
    counter_next    = counter_reg;
    done_write_next = 1'b0;
    done_read_next  = 1'b0;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = line_addr(rd_slot, line_reg);

    // A valid start always wins, whatever operation is in flight.
    if (wr_go) begin
      wr_slot_next = new_slot;
      target_next  = new_target;
      cnt_clear    = 1'b1;
      if (new_target == '0) begin
        done_write_next = 1'b1;
        state_next      = ST_IDLE;
      end else begin
        state_next = ST_WRITE;
      end
    end else if (rd_go) begin
      h_next     = new_h;
      k_next     = first_k;
      line_next  = '0;
      state_next = ST_READ_FETCH;
    end else begin
      case (state_reg)
        ST_WRITE: begin
          if (ready_from_core) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = line_addr(wr_slot_reg, line_t'(wr_cnt));
            cnt_inc  = 1'b1;
            if (wr_cnt + 1'b1 == target_reg) begin
              done_write_next = 1'b1;
              state_next      = ST_IDLE;
            end
          end
        end
        ST_READ_FETCH: begin
          // k == h means no non-empty slot was found in the window.
          if (k_reg >= h_reg) begin
            done_read_next = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            ram_en       = 1'b1;
            counter_next = k_reg;
            state_next   = ST_READ_WAIT;
          end
        end
        ST_READ_WAIT: begin
          if (read_new_line) begin
            if (int'(line_reg) + 1 < int'(rd_cnt)) begin
              line_next  = line_reg + 1'b1;
              state_next = ST_READ_FETCH;
            end else if (nxt_k < h_reg) begin
              k_next     = nxt_k;
              line_next  = '0;
              state_next = ST_READ_FETCH;
            end else begin
              done_read_next = 1'b1;
              state_next     = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_slot_reg    <= '0;
      target_reg     <= '0;
      h_reg          <= '0;
      k_reg          <= '0;
      line_reg       <= '0;
      counter_reg    <= '0;
      done_write_reg <= 1'b0;
      done_read_reg  <= 1'b0;
    end else begin
      wr_slot_reg    <= wr_slot_next;
      target_reg     <= target_next;
      h_reg          <= h_next;
      k_reg          <= k_next;
      line_reg       <= line_next;
      counter_reg    <= counter_next;
      done_write_reg <= done_write_next;
      done_read_reg  <= done_read_next;
    end
  end

  for (genvar gi = 0; gi < HISTORY_DEPTH; gi++) begin : g_line_cnt
    always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N)
        line_cnt_reg[gi] <= '0;
      else if (cnt_clear && wr_slot_next == slot_t'(gi))
        line_cnt_reg[gi] <= '0;
      else if (cnt_inc && wr_slot_reg == slot_t'(gi))
        line_cnt_reg[gi] <= line_cnt_reg[gi] + 1'b1;
    end
  end

  oflow_mem_buffer_ram u_ram (
    .clk     (clk),
    .reset_N (reset_N),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   ({data_in_1, data_in_0}),
    .rdata   (ram_rdata)
  );

  assign done_write                            = done_write_reg;
  assign done_read                             = done_read_reg;
  assign data_out_0                            = ram_rdata[DATA_WIDTH-1:0];
  assign data_out_1                            = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign counter_of_history_frame_to_interface = counter_reg;

endmodule

// File: tb/tb_oflow_mem_buffer_wrapper.sv
// Directed bench: a ring model predicts replayed lines, queued at start_read
// and popped as each line appears on the output bus.
module tb_oflow_mem_buffer_wrapper;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        rnw_st, start_write, start_read, ready_from_core, read_new_line;
  logic [31:0] data_in_0, data_in_1;
  logic [7:0]  frame_num;
  logic [2:0]  num_of_history_frames;
  logic [5:0]  num_of_bbox_in_frame;
  logic        done_write, done_read;
  logic [31:0] data_out_0, data_out_1;
  logic [2:0]  counter_of_history_frame_to_interface;

  always #5 clk = ~clk;

  oflow_mem_buffer_wrapper dut (
    .clk                                   (clk),
    .reset_N                               (reset_N),
    .rnw_st                                (rnw_st),
    .start_write                           (start_write),
    .start_read                            (start_read),
    .ready_from_core                       (ready_from_core),
    .read_new_line                         (read_new_line),
    .data_in_0                             (data_in_0),
    .data_in_1                             (data_in_1),
    .frame_num                             (frame_num),
    .num_of_history_frames                 (num_of_history_frames),
    .num_of_bbox_in_frame                  (num_of_bbox_in_frame),
    .done_write                            (done_write),
    .done_read                             (done_read),
    .data_out_0                            (data_out_0),
    .data_out_1                            (data_out_1),
    .counter_of_history_frame_to_interface (counter_of_history_frame_to_interface)
  );

  typedef struct {
    int          k;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_line_t;

  exp_line_t   exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_slot;
  int          m_cnt [5];
  logic [31:0] m_d0 [5][16];
  logic [31:0] m_d1 [5][16];
  bit          m_writing;
  int          m_target;
  logic [31:0] last_d0, last_d1;
  int          last_k;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, " d0"}, 64'(data_out_0), 64'(last_d0));
    chk({tag, " d1"}, 64'(data_out_1), 64'(last_d1));
    chk({tag, " cnt"}, 64'(counter_of_history_frame_to_interface), 64'(last_k));
  endtask

  task automatic model_reset();
    m_slot    = 0;
    m_writing = 1'b0;
    m_target  = 0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    last_d0 = '0;
    last_d1 = '0;
    last_k  = 0;
  endtask

  task automatic write_start(input int fn, input int bbox);
    rnw_st               = 1'b0;
    frame_num            = 8'(fn);
    num_of_bbox_in_frame = 6'(bbox);
    start_write          = 1'b1;
    tick();
    start_write = 1'b0;
    m_slot   = (fn == 0) ? 0 : (m_slot + 1) % 5;
    m_cnt[m_slot] = 0;
    m_target  = (bbox + 1) / 2;
    if (m_target > 16) m_target = 16;
    m_writing = (m_target != 0);
    $display("write start frame=%0d bbox=%0d done_write=%0b", fn, bbox, done_write);
    chk("done_write start", 64'(done_write), 64'(m_target == 0));
    if (m_target == 0) begin
      tick();
      chk("done_write pulse", 64'(done_write), 64'(0));
    end
  endtask

  task automatic write_line(input int d0, input int d1);
    bit exp_done;
    data_in_0       = 32'(d0);
    data_in_1       = 32'(d1);
    ready_from_core = 1'b1;
    tick();
    ready_from_core = 1'b0;
    exp_done = 1'b0;
    if (m_writing) begin
      m_d0[m_slot][m_cnt[m_slot]] = 32'(d0);
      m_d1[m_slot][m_cnt[m_slot]] = 32'(d1);
      m_cnt[m_slot]++;
      if (m_cnt[m_slot] == m_target) begin
        exp_done  = 1'b1;
        m_writing = 1'b0;
      end
    end
    $display("write line (%0d,%0d) done_write=%0b", d0, d1, done_write);
    chk("done_write line", 64'(done_write), 64'(exp_done));
    if (exp_done) begin
      tick();
      chk("done_write pulse", 64'(done_write), 64'(0));
    end
  endtask

  task automatic read_frame(input int fn, input int nh);
    int        h, s;
    exp_line_t e;
    h = nh;
    if (fn < h) h = fn;
    if (h > 5) h = 5;
    for (int k = 0; k < h; k++) begin
      s = (m_slot - k + 5) % 5;
      for (int l = 0; l < m_cnt[s]; l++) exp_q.push_back('{k: k, d0: m_d0[s][l], d1: m_d1[s][l]});
    end
    m_writing = 1'b0;
    rnw_st                = 1'b1;
    frame_num             = 8'(fn);
    num_of_history_frames = 3'(nh);
    start_read            = 1'b1;
    tick();
    start_read = 1'b0;
    chk("done_read early", 64'(done_read), 64'(0));
    if (exp_q.size() == 0) begin
      tick();
      $display("read frame=%0d nh=%0d empty done_read=%0b", fn, nh, done_read);
      chk("done_read empty", 64'(done_read), 64'(1));
      check_hold("empty hold");
      tick();
      chk("done_read pulse", 64'(done_read), 64'(0));
      return;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      $display("read frame=%0d k=%0d line=(%0d,%0d) exp=(%0d,%0d)",
               fn, counter_of_history_frame_to_interface, data_out_0, data_out_1, e.d0, e.d1);
      chk("rd d0", 64'(data_out_0), 64'(e.d0));
      chk("rd d1", 64'(data_out_1), 64'(e.d1));
      chk("rd cnt", 64'(counter_of_history_frame_to_interface), 64'(e.k));
      chk("done_read mid", 64'(done_read), 64'(0));
      last_d0 = e.d0;
      last_d1 = e.d1;
      last_k  = e.k;
      read_new_line = 1'b1;
      tick();
      read_new_line = 1'b0;
      chk("done_read adv", 64'(done_read), 64'(exp_q.size() == 0));
    end
    tick();
    chk("done_read pulse", 64'(done_read), 64'(0));
    check_hold("post hold");
    read_new_line = 1'b1;
    tick();
    read_new_line = 1'b0;
    chk("done_read extra", 64'(done_read), 64'(0));
    tick();
    check_hold("extra hold");
  endtask

  initial begin
    reset_N = 1'b0;
    rnw_st = 1'b0; start_write = 1'b0; start_read = 1'b0;
    ready_from_core = 1'b0; read_new_line = 1'b0;
    data_in_0 = '0; data_in_1 = '0; frame_num = '0;
    num_of_history_frames = '0; num_of_bbox_in_frame = '0;
    model_reset();
    repeat (3) tick();
    $display("reset state dw=%0b dr=%0b d0=%0d d1=%0d cnt=%0d",
             done_write, done_read, data_out_0, data_out_1, counter_of_history_frame_to_interface);
    chk("rst done_write", 64'(done_write), 64'(0));
    chk("rst done_read", 64'(done_read), 64'(0));
    check_hold("rst");
    reset_N = 1'b1;
    tick();

    // Put something on the bus, then reset in the middle of a write.
    write_start(0, 2);
    write_line(1, 2);
    read_frame(1, 1);
    write_start(0, 8);
    write_line(3, 4);
    #2 reset_N = 1'b0;
    #1;
    model_reset();
    $display("async reset d0=%0d d1=%0d cnt=%0d", data_out_0, data_out_1, counter_of_history_frame_to_interface);
    check_hold("async rst");
    chk("async rst dw", 64'(done_write), 64'(0));
    tick();
    reset_N = 1'b1;
    tick();
    read_frame(1, 1);

    write_start(0, 8);
    write_line(90, 91);
    write_line(5, 6);
    read_frame(1, 1);

    write_start(1, 4);
    write_line(99, 85);
    write_line(77, 88);
    read_frame(2, 3);

    write_start(2, 4);
    write_line(10, 11);
    write_line(12, 13);
    write_line(14, 15);

    for (int f = 0; f <= 6; f++) begin
      write_start(f, 4);
      write_line(f * 100 + 1, f * 100 + 2);
      write_line(f * 100 + 3, f * 100 + 4);
    end
    read_frame(7, 5);

    // start_read while in write mode must be ignored.
    rnw_st     = 1'b0;
    frame_num  = 8'd7;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    chk("gated read dr1", 64'(done_read), 64'(0));
    tick();
    chk("gated read dr2", 64'(done_read), 64'(0));
    tick();
    $display("gated start_read dr=%0b d0=%0d", done_read, data_out_0);
    check_hold("gated read");

    read_frame(0, 5);

    // Empty frame occupies a slot that the replay skips.
    write_start(8, 0);
    read_frame(9, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
